regfile_autofill_top: RTL and testbench
=======================================

// Module: regfile_autofill_top
// PURPOSE
//  Parametrised FPGA test top for the register bank: 2^N x W array, LFSR data source,
//  debounced one-shot buttons, auto-fill state machine and multiplexed 8-digit hex display.
//  Sits directly under the board constraints (100 MHz clk, sw/btn/seg/an pins).
//  Adds over the previous bench: parametrised widths, debounce, hardwired-zero option, bulk fill.
// PARAMETERS
//  N           4          address bits, 1..4 (2^N registers)
//  W           8          data width, 4..16
//  ZERO_REG    1          1: register 0 reads 0 and ignores writes
//  SEED        16'hACE1   LFSR reset value (low W bits used; must be nonzero)
//  DEB_CYCLES  1_000_000  stable cycles before a button level is accepted (10 ms)
//  REFRESH_DIV 100_000    clocks per display digit slot
// PORTS
//  clk      in   1   system clock, all logic on rising edge
//  rst      in   1   reset, asynchronous, active-high
//  sw       in   16  [N-1:0] write addr, [4+N-1:4] rs1 addr, [8+N-1:8] rs2 addr, [15] LFSR freeze
//  btn      in   5   [1] write, [2] display mode toggle, [3] auto-fill start, [0],[4] unused
//  seg      out  7   segments a..g, active-low
//  an       out  8   digit anodes, active-low
//  busy     out  1   high while auto-fill runs
//  fill_done out 1   one-cycle pulse when auto-fill completes
// BEHAVIOUR
//  Reset: all registers 0, LFSR=SEED[W-1:0], FSM=IDLE, mode=0, digit index 0,
//   seg=7'h7F, an=8'hFF, busy=0, fill_done=0. Applies immediately, incl. mid-fill.
//  Buttons: 2-FF synchroniser, then per-button counter; debounced level changes only after
//   DEB_CYCLES consecutive equal samples. Rising edge of debounced level -> 1-cycle pulse.
//   Held button = exactly one pulse; bounce shorter than DEB_CYCLES = no pulse.
//  LFSR: W-bit maximal-length Galois; steps every clock unless sw[15]=1. If state is ever 0,
//   reload SEED on next clock.
//  Manual write: on write pulse in IDLE, reg[sw addr] <= current LFSR value at that edge;
//   visible on read ports the following cycle. Pulse while busy is dropped, not queued.
//  Reads: rs1/rs2 combinational from array; addr 0 returns 0 when ZERO_REG=1.
//  FSM IDLE -> FILL on fill pulse: addr counter=0, busy=1.
//   FILL: each cycle reg[cnt] <= LFSR, cnt++ (reg0 write suppressed if ZERO_REG).
//   FILL -> DONE after writing cnt=2^N-1 (2^N cycles). DONE: fill_done=1, busy=0, -> IDLE.
//   Fill pulse while in FILL/DONE ignored. sw[15]=1 during fill writes same value everywhere.
//  Display: digit index advances every REFRESH_DIV clocks, wraps 7->0; one an bit low at a time.
//   mode 0: rs1 hex on digits [ceil(W/4)-1:0], rs2 hex on digits 4..4+ceil(W/4)-1.
//   mode 1: LFSR value on low digits, write addr (hex) on digit 7, rs2 slot blanked.
//   Mode pulse toggles mode. Unused/blank digit: an bit stays high.
//   seg/an registered: change one clock after index update.
// TESTING (bench params: N=4 W=8 ZERO_REG=1 SEED=8'hA5 DEB_CYCLES=4 REFRESH_DIV=2)
//  1 Hold btn1 20 cycles, sw[3:0]=3 -> exactly one write; reg3 == LFSR value at pulse edge.
//  2 Toggle btn1 every 2 cycles for 30 cycles then low -> no write, all regs stay 0.
//  3 btn3 press -> busy high 16 cycles, fill_done 1 pulse; reg1..15 = 15 consecutive LFSR values, reg0=0.
//  4 btn1 and btn3 pulses during FILL -> no extra write, fill length still 16 cycles.
//  5 rst asserted at cnt=5 in FILL -> busy=0, an=8'hFF, seg=7'h7F same cycle; all regs read 0.
//  6 reg2=8'h3C, sw[7:4]=2 mode 0 -> an scans 8'hFE,8'hFD,..,8'h7F;
//    digit0 seg=7'b0110001 (C), digit1 seg=7'b0000110 (3), digits 2,3,6,7 blank.

Source files
------------

// File: rtl/regfile_autofill_top.sv
// -----------------------------------------------------------------------------
// regfile_autofill_top
// FPGA test top for a 2^N x W register bank. Data comes from a free-running
// Galois LFSR. Buttons are synchronised, debounced and turned into one-cycle
// pulses. They drive a manual write, a display mode toggle and an auto-fill
// state machine that writes every register from the LFSR in 2^N cycles.
// The result is shown on a multiplexed 8-digit hex display.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   sw[15:0]   in   [N-1:0] write addr, [4+N-1:4] rs1 addr, [8+N-1:8] rs2 addr,
//                   [15] LFSR freeze
//   btn[4:0]   in   [1] write, [2] display mode toggle, [3] auto-fill start
//   seg[6:0]   out  segments {a,b,c,d,e,f,g}, active-low
//   an[7:0]    out  digit anodes, active-low
//   busy       out  high while auto-fill runs
//   fill_done  out  one-cycle pulse when auto-fill completes
// -----------------------------------------------------------------------------
module regfile_autofill_top #(
    parameter int          N           = 4,
    parameter int          W           = 8,
    parameter int          ZERO_REG    = 1,
    parameter logic [15:0] SEED        = 16'hACE1,
    parameter int          DEB_CYCLES  = 1_000_000,
    parameter int          REFRESH_DIV = 100_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] sw,
    input  logic [4:0]  btn,
    output logic [6:0]  seg,
    output logic [7:0]  an,
    output logic        busy,
    output logic        fill_done
);

    localparam int DEPTH  = 1 << N;
    localparam int DIGITS = (W + 3) / 4;
    localparam int DCW    = $clog2(DEB_CYCLES + 1);
    localparam int RCW    = $clog2(REFRESH_DIV + 1);
    localparam logic [W-1:0] SEED_W = SEED[W-1:0];

    // Right-shifting Galois feedback masks giving maximal-length sequences.
    function automatic logic [W-1:0] lfsr_taps_f();
        logic [15:0] t;
        case (W)
            32'd4:   t = 16'h000C;
            32'd5:   t = 16'h0014;
            32'd6:   t = 16'h0030;
            32'd7:   t = 16'h0060;
            32'd8:   t = 16'h00B8;
            32'd9:   t = 16'h0110;
            32'd10:  t = 16'h0240;
            32'd11:  t = 16'h0500;
            32'd12:  t = 16'h0E08;
            32'd13:  t = 16'h1C80;
            32'd14:  t = 16'h3802;
            32'd15:  t = 16'h6000;
            default: t = 16'hD008;
        endcase
        return t[W-1:0];
    endfunction

    localparam logic [W-1:0] TAPS = lfsr_taps_f();

    // Hex digit to active-low {a,b,c,d,e,f,g}.
    function automatic logic [6:0] hex7seg_f(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'b0000001;
            4'h1:    s = 7'b1001111;
            4'h2:    s = 7'b0010010;
            4'h3:    s = 7'b0000110;
            4'h4:    s = 7'b1001100;
            4'h5:    s = 7'b0100100;
            4'h6:    s = 7'b0100000;
            4'h7:    s = 7'b0001111;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0000100;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b1100000;
            4'hC:    s = 7'b0110001;
            4'hD:    s = 7'b1000010;
            4'hE:    s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Button index 0/1/2 here corresponds to btn[1]/btn[2]/btn[3].
    logic [2:0]     sync1_q, sync2_q, deb_q, deb_dly_q, pulse_s;
    logic [DCW-1:0] deb_cnt_q [3];
    logic           wr_pulse_s, mode_pulse_s, fill_pulse_s;

    logic [W-1:0]   lfsr_q, lfsr_step_s;
    logic [W-1:0]   regs_q [DEPTH];
    state_t         state_q;
    logic [N-1:0]   cnt_q, waddr_s, rs1_addr_s, rs2_addr_s;
    logic           busy_q, fill_done_q, raw_we_s, we_s;
    logic [W-1:0]   rs1_s, rs2_s;

    logic [RCW-1:0] ref_cnt_q;
    logic [2:0]     idx_q;
    logic           mode_q, in_range_s, blank_s;
    logic [15:0]    rs1_pad_s, rs2_pad_s, lfsr_pad_s;
    logic [3:0]     nib_s;
    logic [6:0]     seg_q;
    logic [7:0]     an_q;
    logic           unused_s;

    // Synchronise, debounce and keep a delayed copy of buttons 1..3.
    // A level is accepted only after DEB_CYCLES consecutive differing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= 3'b000;
            sync2_q   <= 3'b000;
            deb_q     <= 3'b000;
            deb_dly_q <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                deb_cnt_q[i] <= {DCW{1'b0}};
            end
        end else begin
            sync1_q   <= btn[3:1];
            sync2_q   <= sync1_q;
            deb_dly_q <= deb_q;
            for (int i = 0; i < 3; i++) begin
                if (sync2_q[i] != deb_q[i]) begin
                    if (deb_cnt_q[i] == DCW'(DEB_CYCLES - 1)) begin
                        deb_q[i]     <= sync2_q[i];
                        deb_cnt_q[i] <= {DCW{1'b0}};
                    end else begin
                        deb_cnt_q[i] <= deb_cnt_q[i] + DCW'(1'b1);
                    end
                end else begin
                    deb_cnt_q[i] <= {DCW{1'b0}};
                end
            end
        end
    end

    assign pulse_s      = deb_q & ~deb_dly_q;
    assign wr_pulse_s   = pulse_s[0];
    assign mode_pulse_s = pulse_s[1];
    assign fill_pulse_s = pulse_s[2];

    assign lfsr_step_s = {1'b0, lfsr_q[W-1:1]} ^ (lfsr_q[0] ? TAPS : {W{1'b0}});

    // LFSR: steps unless frozen; an all-zero state (lock-up) reloads the seed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= SEED_W;
        end else if (lfsr_q == {W{1'b0}}) begin
            lfsr_q <= SEED_W;
        end else if (!sw[15]) begin
            lfsr_q <= lfsr_step_s;
        end
    end

    // Auto-fill sequencer with registered busy / fill_done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {N{1'b0}};
            busy_q      <= 1'b0;
            fill_done_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    fill_done_q <= 1'b0;
                    if (fill_pulse_s) begin
                        state_q <= ST_FILL;
                        cnt_q   <= {N{1'b0}};
                        busy_q  <= 1'b1;
                    end
                end
                ST_FILL: begin
                    cnt_q <= cnt_q + N'(1'b1);
                    if (cnt_q == N'(DEPTH - 1)) begin
                        state_q     <= ST_DONE;
                        busy_q      <= 1'b0;
                        fill_done_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q     <= ST_IDLE;
                    fill_done_q <= 1'b0;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    busy_q      <= 1'b0;
                    fill_done_q <= 1'b0;
                end
            endcase
        end
    end

    // Write port source: fill counter while filling, manual pulse only in IDLE
    // (pulses in FILL/DONE are dropped rather than queued).
    always_comb begin
        raw_we_s = 1'b0;
        waddr_s  = sw[N-1:0];
        if (state_q == ST_FILL) begin
            raw_we_s = 1'b1;
            waddr_s  = cnt_q;
        end else if (state_q == ST_IDLE) begin
            raw_we_s = wr_pulse_s;
        end else begin
            raw_we_s = 1'b0;
        end
    end

    assign we_s = raw_we_s & ~((ZERO_REG != 32'sd0) && (waddr_s == {N{1'b0}}));

    // Register array, written with the LFSR value present at the write edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= {W{1'b0}};
            end
        end else if (we_s) begin
            regs_q[waddr_s] <= lfsr_q;
        end
    end

    assign rs1_addr_s = sw[4 +: N];
    assign rs2_addr_s = sw[8 +: N];
    assign rs1_s = ((ZERO_REG != 32'sd0) && (rs1_addr_s == {N{1'b0}})) ? {W{1'b0}} : regs_q[rs1_addr_s];
    assign rs2_s = ((ZERO_REG != 32'sd0) && (rs2_addr_s == {N{1'b0}})) ? {W{1'b0}} : regs_q[rs2_addr_s];

    // Digit slot timer and display mode toggle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_cnt_q <= {RCW{1'b0}};
            idx_q     <= 3'd0;
            mode_q    <= 1'b0;
        end else begin
            if (ref_cnt_q == RCW'(REFRESH_DIV - 1)) begin
                ref_cnt_q <= {RCW{1'b0}};
                idx_q     <= idx_q + 3'd1;
            end else begin
                ref_cnt_q <= ref_cnt_q + RCW'(1'b1);
            end
            if (mode_pulse_s) begin
                mode_q <= ~mode_q;
            end
        end
    end

    assign rs1_pad_s  = 16'(rs1_s);
    assign rs2_pad_s  = 16'(rs2_s);
    assign lfsr_pad_s = 16'(lfsr_q);
    // Position within a 4-digit half that actually carries a W-bit value.
    assign in_range_s = ({1'b0, idx_q[1:0]} < 3'(DIGITS));

    // Select the nibble for the current digit slot, or blank it.
    always_comb begin
        nib_s   = 4'h0;
        blank_s = 1'b1;
        if (!mode_q) begin
            if (!idx_q[2] && in_range_s) begin
                nib_s   = rs1_pad_s[{idx_q[1:0], 2'b00} +: 4];
                blank_s = 1'b0;
            end else if (idx_q[2] && in_range_s) begin
                nib_s   = rs2_pad_s[{idx_q[1:0], 2'b00} +: 4];
                blank_s = 1'b0;
            end else begin
                blank_s = 1'b1;
            end
        end else begin
            if (!idx_q[2] && in_range_s) begin
                nib_s   = lfsr_pad_s[{idx_q[1:0], 2'b00} +: 4];
                blank_s = 1'b0;
            end else if (idx_q == 3'd7) begin
                nib_s   = 4'(sw[N-1:0]);
                blank_s = 1'b0;
            end else begin
                blank_s = 1'b1;
            end
        end
    end

    // Registered segment/anode drive; blank slots keep every anode off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q <= 7'h7F;
            an_q  <= 8'hFF;
        end else if (blank_s) begin
            seg_q <= 7'h7F;
            an_q  <= 8'hFF;
        end else begin
            seg_q <= hex7seg_f(nib_s);
            an_q  <= ~(8'h01 << idx_q);
        end
    end

    assign seg       = seg_q;
    assign an        = an_q;
    assign busy      = busy_q;
    assign fill_done = fill_done_q;

    assign unused_s = ^{btn[0], btn[4], sw};

endmodule

// File: tb/tb_regfile_autofill_top.sv
// -----------------------------------------------------------------------------
// tb_regfile_autofill_top
// Directed sequence with an LFSR reference model (polynomial
// x^8+x^6+x^5+x^4+1, the standard maximal 8-bit Galois form). The model keeps
// the LFSR value present at every clock edge so that expected register
// contents follow directly from "write takes the LFSR value at the edge".
// Button latency: 2 synchroniser edges + DEB_CYCLES sampling edges, then the
// pulse is consumed on the next edge.
// -----------------------------------------------------------------------------
module tb_regfile_autofill_top;

    localparam int          N    = 4;
    localparam int          W    = 8;
    localparam logic [15:0] SEED = 16'h00A5;
    localparam int          DEB  = 4;
    localparam int          DIV  = 2;
    localparam int          LAT  = 2 + DEB + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] sw;
    logic [4:0]  btn;
    logic [6:0]  seg;
    logic [7:0]  an;
    logic        busy;
    logic        fill_done;

    int          checks;
    int          failures;
    int          cyc;
    int          disp_base;
    logic [7:0]  m_lfsr;
    logic [7:0]  at_edge [0:4095];

    regfile_autofill_top #(
        .N(N), .W(W), .ZERO_REG(1), .SEED(SEED),
        .DEB_CYCLES(DEB), .REFRESH_DIV(DIV)
    ) dut (
        .clk(clk), .rst(rst), .sw(sw), .btn(btn),
        .seg(seg), .an(an), .busy(busy), .fill_done(fill_done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        // Multiply by x modulo x^8+x^6+x^5+x^4+1 in the reversed Galois form.
        return v[0] ? ((v >> 1) ^ 8'hB8) : (v >> 1);
    endfunction

    function automatic logic [6:0] exp_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'b0000001;
            4'h2:    s = 7'b0010010;
            4'h3:    s = 7'b0000110;
            4'hC:    s = 7'b0110001;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: record the LFSR value seen by this edge, advance the model.
    task automatic tick();
        @(posedge clk);
        if (cyc < 4095) at_edge[cyc + 1] = m_lfsr;
        if (!rst && !sw[15]) m_lfsr = lfsr_next(m_lfsr);
        cyc++;
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Scan the display for n cycles; mode selects the expected digit layout.
    task automatic scan(input int n, input bit mode);
        int d;
        logic [7:0] ean;
        logic [6:0] eseg;
        for (int t = 0; t < n; t++) begin
            tick();
            d = ((cyc - disp_base - 1) / DIV) % 8;
            ean = 8'hFF;
            eseg = 7'h7F;
            if (d == 0) begin ean = 8'hFE; eseg = exp_seg(4'hC); end
            else if (d == 1) begin ean = 8'hFD; eseg = exp_seg(4'h3); end
            else if (!mode && d == 4) begin ean = 8'hEF; eseg = exp_seg(4'h0); end
            else if (!mode && d == 5) begin ean = 8'hDF; eseg = exp_seg(4'h0); end
            else if (mode && d == 7) begin ean = 8'h7F; eseg = exp_seg(4'h2); end
            else begin ean = 8'hFF; eseg = 7'h7F; end
            chk($sformatf("an_m%0d_d%0d", mode, d), an, ean);
            chk($sformatf("seg_m%0d_d%0d", mode, d), seg, eseg);
        end
    endtask

    // Press fill and follow busy/fill_done; optionally inject in-fill pulses.
    task automatic run_fill(input bit inject, input logic [7:0] frozen, input bit use_frozen);
        int p, first, bcnt, dcnt, dat, e;
        p = cyc; first = -1; bcnt = 0; dcnt = 0; dat = -1;
        btn[3] = 1'b1;
        for (int t = 1; t <= 40; t++) begin
            tick();
            if (inject && t == 7) btn[3] = 1'b0;
            if (inject && t == 12) btn = 5'b01010;
            if (busy) begin
                if (first < 0) first = cyc;
                bcnt++;
            end
            if (fill_done) begin dcnt++; dat = cyc; end
        end
        btn = 5'b00000;
        ticks(12);
        e = p + LAT;
        chk("fill_start_edge", first, e);
        chk("fill_busy_len", bcnt, 16);
        chk("fill_done_count", dcnt, 1);
        chk("fill_done_edge", dat, e + 16);
        chk("fill_reg0", dut.regs_q[0], 8'h00);
        for (int i = 1; i < 16; i++)
            chk($sformatf("fill_reg%0d", i), dut.regs_q[i], use_frozen ? frozen : at_edge[e + 1 + i]);
    endtask

    initial begin
        int p;
        bit found;
        checks = 0; failures = 0; cyc = 0; disp_base = 0;
        sw = 16'h0000; btn = 5'b00000; rst = 1'b1; m_lfsr = SEED[7:0];
        ticks(3);
        chk("rst_seg", seg, 7'h7F);
        chk("rst_an", an, 8'hFF);
        chk("rst_busy", busy, 1'b0);
        chk("rst_fill_done", fill_done, 1'b0);
        chk("rst_lfsr", dut.lfsr_q, SEED[7:0]);
        rst = 1'b0;
        disp_base = cyc;
        ticks(5);
        chk("lfsr_track_a", dut.lfsr_q, m_lfsr);

        // Bounce shorter than the debounce window: no write.
        sw = 16'h0005;
        for (int t = 0; t < 30; t++) begin
            if (t % 2 == 0) btn[1] = ~btn[1];
            tick();
        end
        btn[1] = 1'b0;
        ticks(12);
        for (int i = 0; i < 16; i++) chk($sformatf("bounce_reg%0d", i), dut.regs_q[i], 8'h00);

        // Held write button: exactly one write of the LFSR value at the pulse edge.
        sw = 16'h0003;
        p = cyc;
        btn[1] = 1'b1;
        ticks(20);
        btn[1] = 1'b0;
        ticks(12);
        chk("hold_reg3", dut.regs_q[3], at_edge[p + LAT]);
        for (int i = 0; i < 16; i++)
            if (i != 3) chk($sformatf("hold_other%0d", i), dut.regs_q[i], 8'h00);
        chk("lfsr_track_b", dut.lfsr_q, m_lfsr);

        // Plain auto-fill, then auto-fill with write/fill pulses arriving mid-fill.
        sw = 16'h0000;
        run_fill(1'b0, 8'h00, 1'b0);
        sw = 16'h0001;
        run_fill(1'b1, 8'h00, 1'b0);
        chk("busy_idle_after", busy, 1'b0);

        // Reset in the middle of a fill (cnt = 5).
        btn[3] = 1'b1;
        ticks(LAT + 5);
        chk("pre_rst_busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_an", an, 8'hFF);
        chk("midrst_seg", seg, 7'h7F);
        for (int i = 0; i < 16; i++) chk($sformatf("midrst_reg%0d", i), dut.regs_q[i], 8'h00);
        btn = 5'b00000; sw = 16'h0000; m_lfsr = SEED[7:0];
        ticks(3);
        rst = 1'b0;
        disp_base = cyc;
        ticks(2);
        chk("lfsr_track_c", dut.lfsr_q, m_lfsr);

        // Run until the LFSR holds 8'h3C, freeze it and write it to reg2.
        found = 1'b0;
        for (int t = 0; t < 300 && !found; t++) begin
            tick();
            if (m_lfsr == 8'h3C) found = 1'b1;
        end
        chk("lfsr_reach_3c", found, 1'b1);
        sw = 16'h8022;
        btn[1] = 1'b1;
        ticks(10);
        btn[1] = 1'b0;
        ticks(8);
        chk("frozen_lfsr", dut.lfsr_q, 8'h3C);
        chk("reg2_3c", dut.regs_q[2], 8'h3C);

        // Display in mode 0 (rs1=reg2, rs2=reg0), then mode 1.
        scan(32, 1'b0);
        btn[2] = 1'b1;
        ticks(10);
        btn[2] = 1'b0;
        ticks(8);
        scan(32, 1'b1);

        // Fill with the LFSR frozen: every register gets the same value.
        run_fill(1'b0, 8'h3C, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
